ram_block_mover: RTL and testbench

- Memory-side initiator for the 4K-word single-port RAM. It drives the RAM's in/load/address port and reads its out bus.
- Performs either a block copy (src to dst) or a block fill with a constant, word by word, under a start/busy/done handshake.
- Sits between the CPU control logic (or a boot loader) and the RAM4K data port, multiplexed with the CPU's own memory port by the owner of the bus.

---
 rtl/ram_block_mover.sv | 114 +++++++++++
 tb/tb_ram_block_mover.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_block_mover.sv
// Word-by-word block copy / block fill engine driving the single-port RAM4K data port.
// Every output is a flop, loaded with the value belonging to the state being entered.
module ram_block_mover #(
    parameter int AW = 12,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          mode,
    input  logic [AW-1:0] src,
    input  logic [AW-1:0] dst,
    input  logic [AW:0]   len,
    input  logic [DW-1:0] fill_value,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   count,
    output logic [AW-1:0] ram_address,
    output logic          ram_load,
    output logic [DW-1:0] ram_in,
    input  logic [DW-1:0] ram_out
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t        state;
    logic          mode_q;
    logic [AW-1:0] src_ptr;
    logic [AW-1:0] dst_ptr;
    logic [AW:0]   remaining;

    // ram_in doubles as the copy data register and as the latched fill word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            mode_q      <= 1'b0;
            src_ptr     <= '0;
            dst_ptr     <= '0;
            remaining   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            count       <= '0;
            ram_address <= '0;
            ram_load    <= 1'b0;
            ram_in      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    busy        <= 1'b0;
                    done        <= 1'b0;
                    ram_load    <= 1'b0;
                    ram_address <= '0;
                    ram_in      <= '0;
                    if (start) begin
                        mode_q    <= mode;
                        src_ptr   <= src;
                        dst_ptr   <= dst;
                        remaining <= len;
                        count     <= '0;
                        busy      <= 1'b1;
                        if (len == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else if (!mode) begin
                            state       <= READ;
                            ram_address <= src;
                        end else begin
                            state       <= WRITE;
                            ram_address <= dst;
                            ram_load    <= 1'b1;
                            ram_in      <= fill_value;
                        end
                    end
                end
                READ: begin
                    state       <= WRITE;
                    ram_address <= dst_ptr;
                    ram_load    <= 1'b1;
                    ram_in      <= ram_out;
                end
                WRITE: begin
                    dst_ptr   <= dst_ptr + 1'b1;
                    remaining <= remaining - 1'b1;
                    count     <= count + 1'b1;
                    if (!mode_q)
                        src_ptr <= src_ptr + 1'b1;
                    if (remaining == (AW+1)'(1)) begin
                        state       <= DONE;
                        done        <= 1'b1;
                        ram_load    <= 1'b0;
                        ram_address <= '0;
                        ram_in      <= '0;
                    end else if (!mode_q) begin
                        state       <= READ;
                        ram_load    <= 1'b0;
                        ram_address <= src_ptr + 1'b1;
                    end else begin
                        ram_address <= dst_ptr + 1'b1;
                    end
                end
                DONE: begin
                    state       <= IDLE;
                    busy        <= 1'b0;
                    done        <= 1'b0;
                    ram_load    <= 1'b0;
                    ram_address <= '0;
                    ram_in      <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_block_mover.sv
// Randomized scoreboard bench for ram_block_mover with a behavioural RAM and transfer model.
module tb_ram_block_mover;

    localparam int AW = 12;
    localparam int DW = 16;
    localparam int NW = 4096;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          mode = 1'b0;
    logic [AW-1:0] src = '0;
    logic [AW-1:0] dst = '0;
    logic [AW:0]   len = '0;
    logic [DW-1:0] fill_value = '0;
    logic          busy, done, ram_load;
    logic [AW:0]   count;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_in, ram_out;

    ram_block_mover #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .src(src), .dst(dst),
        .len(len), .fill_value(fill_value), .busy(busy), .done(done), .count(count),
        .ram_address(ram_address), .ram_load(ram_load), .ram_in(ram_in), .ram_out(ram_out)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [0:NW-1];
    logic [DW-1:0] model_mem [0:NW-1];
    int commits = 0;

    assign ram_out = mem[ram_address];

    always @(posedge clk) begin
        if (ram_load) begin
            mem[ram_address] <= ram_in;
            commits <= commits + 1;
        end
    end

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t exp_wr[$];
    int  exp_done[$];
    int  checks = 0;
    int  failures = 0;

    // Monitor: every presented write and every done pulse is matched against the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            if (ram_load) begin
                checks++;
                if (exp_wr.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_write addr=%h data=%h", ram_address, ram_in);
                end else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    if (ram_address !== e.a || ram_in !== e.d) begin
                        failures++;
                        $display("FAIL write got addr=%h data=%h exp addr=%h data=%h",
                                 ram_address, ram_in, e.a, e.d);
                    end
                end
            end
            if (done) begin
                checks++;
                if (exp_done.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_done count=%0d", count);
                end else begin
                    int ec;
                    ec = exp_done.pop_front();
                    if (count !== (AW+1)'(ec)) begin
                        failures++;
                        $display("FAIL done_count got=%0d exp=%0d", count, ec);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic poke(input int a, input logic [DW-1:0] d);
        mem[a] = d;
        model_mem[a] = d;
    endtask

    // Reference: forward word-by-word transfer on a flat array with modulo addressing.
    task automatic model_op(input logic m, input int s, input int d, input int n,
                            input logic [DW-1:0] fv, input int n_commit, input int n_present);
        for (int i = 0; i < n_present; i++) begin
            wr_t w;
            w.a = AW'((d + i) % NW);
            w.d = m ? fv : model_mem[(s + i) % NW];
            exp_wr.push_back(w);
            if (i < n_commit) model_mem[w.a] = w.d;
        end
        if (n_commit == n) exp_done.push_back(n);
    endtask

    task automatic scramble_operands();
        mode = 1'($urandom);
        src = AW'($urandom);
        dst = AW'($urandom);
        len = (AW+1)'($urandom_range(1, 30));
        fill_value = DW'($urandom);
    endtask

    task automatic run_op(input logic m, input int s, input int d, input int n,
                          input logic [DW-1:0] fv, input bit spam);
        int cycles;
        int exp_lat;
        bit busy_ok;
        model_op(m, s, d, n, fv, n, n);
        exp_lat = (n == 0) ? 1 : (m ? n + 1 : 2 * n + 1);
        @(negedge clk);
        mode = m; src = AW'(s); dst = AW'(d); len = (AW+1)'(n); fill_value = fv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = spam;
        scramble_operands();
        cycles = 0;
        busy_ok = 1'b1;
        forever begin
            @(negedge clk);
            cycles++;
            if (!busy) busy_ok = 1'b0;
            if (done || cycles > 20000) break;
            if (spam) scramble_operands();
        end
        check("latency", 32'(cycles), 32'(exp_lat));
        check("busy_during_op", 32'(busy_ok), 32'd1);
        if (spam) begin
            @(posedge clk);
            #1 start = 1'b0;
        end
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_done", 32'(done), 32'd0);
        check("count_hold", 32'(count), 32'(n));
        check("idle_load", 32'(ram_load), 32'd0);
    endtask

    initial begin
        int base;
        int bad;
        int first_bad;
        for (int i = 0; i < NW; i++) poke(i, DW'($urandom));
        #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_addr", 32'(ram_address), 32'd0);
        check("rst_load", 32'(ram_load), 32'd0);
        check("rst_in", 32'(ram_in), 32'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        run_op(1'b1, 0, 12'h100, 4, 16'hBEEF, 1'b0);
        poke(12'h010, 16'h1111); poke(12'h011, 16'h2222); poke(12'h012, 16'h3333);
        run_op(1'b0, 12'h010, 12'h800, 3, 16'h0, 1'b0);
        run_op(1'b1, 0, 12'hFFE, 4, 16'h00AA, 1'b0);
        run_op(1'b0, 5, 6, 0, 16'h0, 1'b0);
        run_op(1'b1, 0, 12'h200, 8, 16'h5A5A, 1'b1);
        poke(0, 16'd1); poke(1, 16'd2); poke(2, 16'd3); poke(3, 16'd4);
        run_op(1'b0, 0, 1, 3, 16'h0, 1'b0);
        check("overlap_word3", 32'(mem[3]), 32'd1);
        run_op(1'b0, 12'hFFD, 12'h7FE, 6, 16'h0, 1'b0);

        // Mid-operation reset: three writes presented, the third never commits.
        model_op(1'b1, 0, 12'h300, 10, 16'hC0DE, 2, 3);
        @(negedge clk);
        mode = 1'b1; dst = 12'h300; len = 10; fill_value = 16'hC0DE; start = 1'b1;
        @(posedge clk);
        base = commits;
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("mid_rst_load", 32'(ram_load), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_count", 32'(count), 32'd0);
        @(posedge clk);
        #1;
        check("mid_rst_commits", 32'(commits - base), 32'd2);
        check("mid_rst_queue", 32'(exp_wr.size()), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run_op(1'b1, 0, 12'h400, 3, 16'h1234, 1'b0);

        for (int k = 0; k < 10; k++) begin
            logic          rm;
            int            rs, rd, rn;
            rm = 1'($urandom);
            rs = (k % 3 == 0) ? $urandom_range(4080, 4095) : $urandom_range(0, 4095);
            rd = (k % 2 == 0) ? $urandom_range(4085, 4095) : $urandom_range(0, 4095);
            rn = $urandom_range(0, 24);
            run_op(rm, rs, rd, rn, DW'($urandom), 1'($urandom));
        end
        run_op(1'b1, 0, 12'h123, 4096, 16'h7E7E, 1'b0);

        check("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
        check("done_queue_empty", 32'(exp_done.size()), 32'd0);
        bad = 0;
        first_bad = -1;
        for (int i = 0; i < NW; i++) begin
            if (mem[i] !== model_mem[i]) begin
                bad++;
                if (first_bad < 0) first_bad = i;
            end
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL ram_contents mismatching_words=%0d first_addr=%0h required=0",
                     bad, first_bad);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
